// File: rtl/rf_writeback.sv
// Register-file write side: merges ALU results and load responses into one write port (1-cycle latency).
// One load tracked at a time; ALU/load collisions park in a one-entry hold, ALU backpressured while it is full.
module rf_writeback #(
  parameter int XLEN    = 32,
  parameter int RADDR_W = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               alu_valid_i,
  output logic               alu_ready_o,
  input  logic [RADDR_W-1:0] alu_rd_i,
  input  logic [XLEN-1:0]    alu_data_i,
  input  logic               ld_req_valid_i,
  output logic               ld_req_ready_o,
  input  logic [RADDR_W-1:0] ld_rd_i,
  input  logic [1:0]         ld_size_i,
  input  logic               ld_signed_i,
  input  logic [1:0]         ld_offset_i,
  input  logic               ld_rsp_valid_i,
  input  logic [XLEN-1:0]    ld_rsp_data_i,
  input  logic               ld_rsp_err_i,
  input  logic [RADDR_W-1:0] rs1_addr_i,
  input  logic [RADDR_W-1:0] rs2_addr_i,
  output logic               rf_we_o,
  output logic [RADDR_W-1:0] rf_rd_addr_o,
  output logic [XLEN-1:0]    rf_rd_data_o,
  output logic               ld_pending_o,
  output logic               hazard_o,
  output logic               ld_err_o
);

  typedef enum logic {IDLE, WAIT_RSP} state_t;

  typedef struct packed {
    logic [RADDR_W-1:0] rd;
    logic [1:0]         size;
    logic               sgn;
    logic [1:0]         off;
  } ld_ctx_t;

  typedef struct packed {
    logic [RADDR_W-1:0] rd;
    logic [XLEN-1:0]    dat;
  } wb_t;

  state_t  state, state_nxt;
  ld_ctx_t pend;
  wb_t     hold;
  logic    hold_full;

  logic rsp_fire, rsp_ok, req_fire, alu_fire;
  wb_t  wr;
  logic wr_vld, park, drain;

  function automatic logic [XLEN-1:0] fmt_load(input logic [XLEN-1:0] raw, input ld_ctx_t c);
    logic [7:0]      b;
    logic [15:0]     h;
    logic [XLEN-1:0] r;
    b = raw[8*c.off +: 8];
    h = c.off[1] ? raw[31:16] : raw[15:0];
    case (c.size)
      2'd0:    r = {{(XLEN-8){c.sgn & b[7]}}, b};
      2'd1:    r = {{(XLEN-16){c.sgn & h[15]}}, h};
      default: r = raw;
    endcase
    return r;
  endfunction

  function automatic logic rs_hit(input logic [RADDR_W-1:0] rd);
    return (rd != '0) && ((rs1_addr_i == rd) || (rs2_addr_i == rd));
  endfunction

  assign rsp_fire       = (state == WAIT_RSP) && ld_rsp_valid_i;
  assign rsp_ok         = rsp_fire && !ld_rsp_err_i;
  assign ld_req_ready_o = (state == IDLE) || ld_rsp_valid_i;
  assign req_fire       = ld_req_valid_i && ld_req_ready_o;
  assign alu_ready_o    = !hold_full;
  assign alu_fire       = alu_valid_i && alu_ready_o;
  assign ld_pending_o   = (state == WAIT_RSP);
  assign hazard_o       = (ld_pending_o && rs_hit(pend.rd)) || (hold_full && rs_hit(hold.rd));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (req_fire)      state_nxt = WAIT_RSP;
    else if (rsp_fire) state_nxt = IDLE;
  end

  // Priority: load response, then hold entry, then a fresh ALU result.
  // Results targeting x0 are consumed without a write and never parked.
  always_comb begin
    wr     = '0;
    wr_vld = 1'b0;
    park   = 1'b0;
    drain  = 1'b0;
    if (rsp_ok) begin
      wr.rd  = pend.rd;
      wr.dat = fmt_load(ld_rsp_data_i, pend);
      wr_vld = (pend.rd != '0);
      park   = alu_fire && (alu_rd_i != '0);
    end else if (hold_full) begin
      wr     = hold;
      wr_vld = 1'b1;
      drain  = 1'b1;
    end else if (alu_fire) begin
      wr.rd  = alu_rd_i;
      wr.dat = alu_data_i;
      wr_vld = (alu_rd_i != '0);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pend         <= '0;
      hold         <= '0;
      hold_full    <= 1'b0;
      rf_we_o      <= 1'b0;
      rf_rd_addr_o <= '0;
      rf_rd_data_o <= '0;
      ld_err_o     <= 1'b0;
    end else begin
      if (req_fire) pend <= '{rd: ld_rd_i, size: ld_size_i, sgn: ld_signed_i, off: ld_offset_i};
      if (park) begin
        hold      <= '{rd: alu_rd_i, dat: alu_data_i};
        hold_full <= 1'b1;
      end else if (drain) begin
        hold_full <= 1'b0;
      end
      rf_we_o <= wr_vld;
      if (wr_vld) begin
        rf_rd_addr_o <= wr.rd;
        rf_rd_data_o <= wr.dat;
      end
      ld_err_o <= rsp_fire && ld_rsp_err_i;
    end
  end

endmodule

// File: tb/tb_rf_writeback.sv
// Bench for rf_writeback: format vector table, directed corner sequences, then random traffic vs a queue model.
module tb_rf_writeback;

  logic        clk = 1'b0;
  logic        rst;
  logic        alu_valid_i, alu_ready_o;
  logic [4:0]  alu_rd_i;
  logic [31:0] alu_data_i;
  logic        ld_req_valid_i, ld_req_ready_o;
  logic [4:0]  ld_rd_i;
  logic [1:0]  ld_size_i;
  logic        ld_signed_i;
  logic [1:0]  ld_offset_i;
  logic        ld_rsp_valid_i;
  logic [31:0] ld_rsp_data_i;
  logic        ld_rsp_err_i;
  logic [4:0]  rs1_addr_i, rs2_addr_i;
  logic        rf_we_o;
  logic [4:0]  rf_rd_addr_o;
  logic [31:0] rf_rd_data_o;
  logic        ld_pending_o, hazard_o, ld_err_o;

  rf_writeback #(.XLEN(32), .RADDR_W(5)) dut (
    .clk(clk), .rst(rst),
    .alu_valid_i(alu_valid_i), .alu_ready_o(alu_ready_o), .alu_rd_i(alu_rd_i), .alu_data_i(alu_data_i),
    .ld_req_valid_i(ld_req_valid_i), .ld_req_ready_o(ld_req_ready_o), .ld_rd_i(ld_rd_i),
    .ld_size_i(ld_size_i), .ld_signed_i(ld_signed_i), .ld_offset_i(ld_offset_i),
    .ld_rsp_valid_i(ld_rsp_valid_i), .ld_rsp_data_i(ld_rsp_data_i), .ld_rsp_err_i(ld_rsp_err_i),
    .rs1_addr_i(rs1_addr_i), .rs2_addr_i(rs2_addr_i),
    .rf_we_o(rf_we_o), .rf_rd_addr_o(rf_rd_addr_o), .rf_rd_data_o(rf_rd_data_o),
    .ld_pending_o(ld_pending_o), .hazard_o(hazard_o), .ld_err_o(ld_err_o)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
  } ent_t;

  typedef struct {
    logic [1:0]  size;
    logic        sgn;
    logic [1:0]  off;
    logic [31:0] data;
    logic [31:0] exp;
  } fmt_vec_t;

  // Reference state: one outstanding load and a queue of parked ALU results.
  bit         m_pend;
  logic [4:0] m_rd;
  logic [1:0] m_size, m_off;
  logic       m_sgn;
  ent_t       parked[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] fmt(input logic [31:0] d, input logic [1:0] size,
                                      input logic sgn, input logic [1:0] off);
    longint v;
    case (size)
      2'd0: begin
        v = (longint'(d) >> (8 * off)) & 255;
        if (sgn && v >= 128) v = v - 256;
      end
      2'd1: begin
        v = (longint'(d) >> (16 * (off / 2))) & 65535;
        if (sgn && v >= 32768) v = v - 65536;
      end
      default: v = longint'(d);
    endcase
    return v[31:0];
  endfunction

  function automatic bit hit(input logic [4:0] rd);
    return rd != 0 && (rs1_addr_i == rd || rs2_addr_i == rd);
  endfunction

  function automatic bit model_hazard();
    bit h = 0;
    if (m_pend && hit(m_rd)) h = 1;
    if (parked.size() > 0 && hit(parked[0].rd)) h = 1;
    return h;
  endfunction

  task automatic idle_inputs();
    alu_valid_i = 0; alu_rd_i = 0; alu_data_i = 0;
    ld_req_valid_i = 0; ld_rd_i = 0; ld_size_i = 0; ld_signed_i = 0; ld_offset_i = 0;
    ld_rsp_valid_i = 0; ld_rsp_data_i = 0; ld_rsp_err_i = 0;
  endtask

  // Called at the negedge with inputs already driven; checks combinational outputs,
  // advances the model, then checks registered outputs just after the posedge.
  task automatic cycle();
    bit          rsp_taken, alu_acc, req_acc;
    logic        exp_we, exp_err;
    logic [4:0]  exp_rd;
    logic [31:0] exp_dat;
    ent_t        e;
    #1;
    chk("alu_ready", alu_ready_o, parked.size() == 0);
    chk("ld_req_ready", ld_req_ready_o, !m_pend || ld_rsp_valid_i);
    chk("hazard", hazard_o, model_hazard());
    chk("ld_pending", ld_pending_o, m_pend);
    rsp_taken = m_pend && ld_rsp_valid_i;
    alu_acc   = alu_valid_i && parked.size() == 0;
    req_acc   = ld_req_valid_i && (!m_pend || ld_rsp_valid_i);
    exp_err   = rsp_taken && ld_rsp_err_i;
    exp_we = 0; exp_rd = 0; exp_dat = 0;
    if (rsp_taken && !ld_rsp_err_i) begin
      exp_rd  = m_rd;
      exp_dat = fmt(ld_rsp_data_i, m_size, m_sgn, m_off);
      exp_we  = m_rd != 0;
      if (alu_acc && alu_rd_i != 0) begin
        e.rd = alu_rd_i; e.data = alu_data_i;
        parked.push_back(e);
      end
    end else if (parked.size() > 0) begin
      e = parked.pop_front();
      exp_rd = e.rd; exp_dat = e.data; exp_we = 1;
    end else if (alu_acc) begin
      exp_rd = alu_rd_i; exp_dat = alu_data_i; exp_we = alu_rd_i != 0;
    end
    if (req_acc) begin
      m_pend = 1; m_rd = ld_rd_i; m_size = ld_size_i; m_sgn = ld_signed_i; m_off = ld_offset_i;
    end else if (rsp_taken) begin
      m_pend = 0;
    end
    @(posedge clk);
    #1;
    chk("rf_we", rf_we_o, exp_we);
    if (exp_we) begin
      chk("rf_addr", rf_rd_addr_o, exp_rd);
      chk("rf_data", rf_rd_data_o, exp_dat);
    end
    chk("ld_err", ld_err_o, exp_err);
    chk("pending_next", ld_pending_o, m_pend);
    @(negedge clk);
  endtask

  task automatic issue_load(input logic [4:0] rd, input logic [1:0] size, input logic sgn,
                            input logic [1:0] off);
    ld_req_valid_i = 1; ld_rd_i = rd; ld_size_i = size; ld_signed_i = sgn; ld_offset_i = off;
    cycle();
    ld_req_valid_i = 0;
  endtask

  fmt_vec_t vt[9];

  initial begin
    vt[0] = '{2'd0, 1'b1, 2'd3, 32'h80123456, 32'hFFFFFF80};
    vt[1] = '{2'd0, 1'b0, 2'd3, 32'h80123456, 32'h00000080};
    vt[2] = '{2'd1, 1'b1, 2'd2, 32'hBEEF0000, 32'hFFFFBEEF};
    vt[3] = '{2'd1, 1'b0, 2'd1, 32'h1234ABCD, 32'h0000ABCD};
    vt[4] = '{2'd0, 1'b1, 2'd0, 32'h1234567F, 32'h0000007F};
    vt[5] = '{2'd0, 1'b1, 2'd1, 32'h0000A500, 32'hFFFFFFA5};
    vt[6] = '{2'd3, 1'b1, 2'd2, 32'hCAFEF00D, 32'hCAFEF00D};
    vt[7] = '{2'd1, 1'b0, 2'd3, 32'h8001FFFF, 32'h00008001};
    vt[8] = '{2'd2, 1'b0, 2'd1, 32'hDEAD0001, 32'hDEAD0001};

    rst = 0; rs1_addr_i = 0; rs2_addr_i = 0;
    idle_inputs();
    m_pend = 0;
    repeat (3) @(posedge clk);
    @(negedge clk); #1;
    chk("rst_we", rf_we_o, 0);
    chk("rst_addr", rf_rd_addr_o, 0);
    chk("rst_data", rf_rd_data_o, 0);
    chk("rst_pending", ld_pending_o, 0);
    chk("rst_err", ld_err_o, 0);
    chk("rst_alu_ready", alu_ready_o, 1);
    chk("rst_ld_req_ready", ld_req_ready_o, 1);
    chk("rst_hazard", hazard_o, 0);
    rst = 1;

    // ALU only
    alu_valid_i = 1; alu_rd_i = 5; alu_data_i = 32'hDEADBEEF;
    cycle();
    chk("alu_we", rf_we_o, 1);
    chk("alu_addr", rf_rd_addr_o, 5);
    chk("alu_data", rf_rd_data_o, 32'hDEADBEEF);
    chk("alu_ready_after", alu_ready_o, 1);
    idle_inputs();

    // Load formatting table
    for (int i = 0; i < 9; i++) begin
      issue_load(5'd9, vt[i].size, vt[i].sgn, vt[i].off);
      ld_rsp_valid_i = 1; ld_rsp_data_i = vt[i].data;
      cycle();
      chk($sformatf("fmt%0d_we", i), rf_we_o, 1);
      chk($sformatf("fmt%0d_data", i), rf_rd_data_o, vt[i].exp);
      ld_rsp_valid_i = 0;
    end

    // Collision: load wins, ALU parks, further ALU stalled
    issue_load(5'd7, 2'd2, 1'b0, 2'd0);
    ld_rsp_valid_i = 1; ld_rsp_data_i = 32'h11;
    alu_valid_i = 1; alu_rd_i = 8; alu_data_i = 32'h22;
    cycle();
    chk("col_addr1", rf_rd_addr_o, 7);
    chk("col_data1", rf_rd_data_o, 32'h11);
    ld_rsp_valid_i = 0;
    alu_rd_i = 9; alu_data_i = 32'h33;
    #1 chk("col_stall", alu_ready_o, 0);
    cycle();
    chk("col_addr2", rf_rd_addr_o, 8);
    chk("col_data2", rf_rd_data_o, 32'h22);
    cycle();
    chk("col_addr3", rf_rd_addr_o, 9);
    chk("col_data3", rf_rd_data_o, 32'h33);
    idle_inputs();

    // Hazard
    issue_load(5'd10, 2'd2, 1'b0, 2'd0);
    rs1_addr_i = 10; rs2_addr_i = 0;
    #1 chk("haz_rs1", hazard_o, 1);
    rs1_addr_i = 3; rs2_addr_i = 10;
    #1 chk("haz_rs2", hazard_o, 1);
    ld_rsp_valid_i = 1; ld_rsp_data_i = 32'h5;
    cycle();
    ld_rsp_valid_i = 0;
    #1 chk("haz_clear", hazard_o, 0);
    issue_load(5'd0, 2'd2, 1'b0, 2'd0);
    rs1_addr_i = 0; rs2_addr_i = 0;
    #1 chk("haz_x0", hazard_o, 0);
    chk("x0_pending", ld_pending_o, 1);
    ld_rsp_valid_i = 1; ld_rsp_data_i = 32'h99;
    cycle();
    chk("x0_no_we", rf_we_o, 0);
    idle_inputs();

    // Error response, then response while idle
    issue_load(5'd3, 2'd2, 1'b0, 2'd0);
    ld_rsp_valid_i = 1; ld_rsp_err_i = 1; ld_rsp_data_i = 32'hAB;
    cycle();
    chk("err_no_we", rf_we_o, 0);
    chk("err_pulse", ld_err_o, 1);
    chk("err_pending", ld_pending_o, 0);
    cycle();
    chk("idle_rsp_we", rf_we_o, 0);
    chk("idle_rsp_err", ld_err_o, 0);
    idle_inputs();
    cycle();

    // Async reset while waiting with hold full
    issue_load(5'd1, 2'd2, 1'b0, 2'd0);
    ld_req_valid_i = 1; ld_rd_i = 3;
    ld_rsp_valid_i = 1; ld_rsp_data_i = 32'h55;
    alu_valid_i = 1; alu_rd_i = 2; alu_data_i = 32'h66;
    cycle();
    idle_inputs();
    rs1_addr_i = 2; rs2_addr_i = 3;
    #1;
    chk("pre_rst_pending", ld_pending_o, 1);
    chk("pre_rst_alu_ready", alu_ready_o, 0);
    rst = 0;
    #1;
    chk("arst_we", rf_we_o, 0);
    chk("arst_addr", rf_rd_addr_o, 0);
    chk("arst_data", rf_rd_data_o, 0);
    chk("arst_pending", ld_pending_o, 0);
    chk("arst_err", ld_err_o, 0);
    chk("arst_hazard", hazard_o, 0);
    chk("arst_alu_ready", alu_ready_o, 1);
    chk("arst_ld_req_ready", ld_req_ready_o, 1);
    m_pend = 0; parked.delete();
    @(posedge clk);
    @(negedge clk);
    rst = 1;
    ld_rsp_valid_i = 1; ld_rsp_data_i = 32'h77;
    cycle();
    chk("late_rsp_we", rf_we_o, 0);
    idle_inputs();
    cycle();

    // Random traffic
    for (int c = 0; c < 3000; c++) begin
      alu_valid_i    = ($urandom_range(0, 1) == 1);
      alu_rd_i       = 5'($urandom_range(0, 7));
      alu_data_i     = $urandom;
      ld_req_valid_i = ($urandom_range(0, 2) == 0);
      ld_rd_i        = 5'($urandom_range(0, 7));
      ld_size_i      = 2'($urandom_range(0, 3));
      ld_signed_i    = 1'($urandom_range(0, 1));
      ld_offset_i    = 2'($urandom_range(0, 3));
      ld_rsp_valid_i = ($urandom_range(0, 4) < 2);
      ld_rsp_data_i  = $urandom;
      ld_rsp_err_i   = ($urandom_range(0, 9) == 0);
      rs1_addr_i     = 5'($urandom_range(0, 7));
      rs2_addr_i     = 5'($urandom_range(0, 7));
      cycle();
    end
    idle_inputs();
    cycle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
